ring_decoder: RTL and testbench
===============================

# ring_decoder

Receive-side companion to the 4-bit ring counter. Samples a one-hot ring vector each qualified clock, decodes it to a binary index, and checks that it advances in ring order (bit i → bit i+1, MSB → bit 0). Acquires and holds lock on a correctly rotating sequence, and flags malformed vectors and sequence slips. Sits next to any ring-counter source as a phase decoder and health monitor.

## Interface
- WIDTH, 4 — ring length in bits; must be ≥ 2.
- LOCK_CNT, 3 — consecutive correctly ordered samples required to declare lock; must be ≥ 2.
- MISS_LIMIT, 2 — consecutive bad samples in LOCKED that drop lock; must be ≥ 1.
- Clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — reset, asynchronous and active-low; 0 resets immediately.
- in_valid  in  1  — ring_in is sampled only on edges where this is 1.
- ring_in  in  WIDTH  — ring vector under test.
- idx  out  $clog2(WIDTH)  — bit position of the set bit in the last valid one-hot sample.
- idx_valid  out  1  — 1 when the last valid sample was one-hot.
- locked  out  1  — 1 while the FSM is in LOCKED.
- onehot_err  out  1  — 1-cycle pulse: a sample that is not one-hot arrived while LOCKED.
- seq_err  out  1  — 1-cycle pulse: a one-hot sample arrived while LOCKED but was not the expected rotation.
- cycle_done  out  1  — 1-cycle pulse: a matched sample arrived while LOCKED with idx = 0 (ring wrapped).
- err_count  out  8  — saturating count of onehot_err plus seq_err pulses; holds at 255.

## Operation
- One-hot check: exactly one bit set. All-zero and multi-bit vectors are not one-hot.
- Expected next value is `exp = rotl(prev, 1)`, where `prev` is the internal reference register.
- FSM states: SEARCH, ACQUIRE, LOCKED.
- **SEARCH**
  - Valid one-hot sample → ACQUIRE, with good_cnt = 1 and prev = sample.
  - Otherwise stay in SEARCH.
- **ACQUIRE**
  - Valid sample equal to exp → good_cnt + 1 and prev = sample. When good_cnt reaches LOCK_CNT → LOCKED, with miss_cnt = 0.
  - Valid one-hot sample not equal to exp → stay in ACQUIRE, with good_cnt = 1 and prev = sample.
  - Valid non-one-hot sample → SEARCH, with good_cnt = 0.
- **LOCKED**
  - Valid sample equal to exp → prev = sample and miss_cnt = 0. Assert cycle_done if the sample's idx = 0.
  - Valid bad sample → pulse onehot_err (not one-hot) or seq_err (one-hot but wrong). Exactly one of the two fires.
    - err_count + 1, saturating.
    - miss_cnt + 1.
    - prev = exp (flywheel: the reference keeps rotating).
    - When miss_cnt reaches MISS_LIMIT → SEARCH, with good_cnt = 0 and miss_cnt = 0.
- in_valid = 0: no state, counter, prev, or output change, and no pulses.
- No error pulses are produced in SEARCH or ACQUIRE.
- idx and idx_valid update on every valid sample in all states.
  - Non-one-hot sample: idx_valid = 0 and idx holds its previous value.
- err_count clears only on reset.

## Timing
- All outputs are registered. A sample taken on edge N is reflected on the outputs after edge N (1-cycle latency).
- Pulses (onehot_err, seq_err, cycle_done) are high for exactly one cycle per qualifying sample.
- locked rises on the edge of the LOCK_CNT-th consecutive good sample. That is LOCK_CNT valid samples after the first one-hot sample, counting the first.
- locked falls on the edge of the MISS_LIMIT-th consecutive bad sample. The error pulse for that sample fires on the same edge.
- Reset takes effect immediately on rst = 0, mid-operation included:
  - FSM to SEARCH.
  - idx = 0, idx_valid = 0, locked = 0, all pulses = 0, err_count = 0.
  - prev = 0, good_cnt = 0, miss_cnt = 0.
- First edge after rst returns to 1: the sample is handled as in SEARCH.

## Structure
- Package `ring_pkg` holds:
  - The state enum for SEARCH/ACQUIRE/LOCKED.
  - The rotl function.
  - The 8-bit err_count width constant.
- Sub-module `ring_onehot_decode` is purely combinational and parameterised by WIDTH.
  - Outputs: is_onehot and the index.
- The FSM, counters and output registers live in ring_decoder.

## Test plan
- **Reset:** hold rst = 0 with random ring_in → all outputs 0. Release, then feed 0001, 0010, 0100 with in_valid = 1 → locked = 1 after the third sample, idx = 0, 1, 2.
- **Wrap:** locked stream 0100, 1000, 0001 → idx = 3, then 0. cycle_done pulses once, on the 0001 sample. No errors.
- **Slip in LOCKED:** expected 0010, feed 1000 → seq_err pulse, err_count = 1, locked stays 1. Next 0100 (flywheel match) → no error and miss_cnt cleared.
- **Loss of lock:** two consecutive 0000 samples while LOCKED → two onehot_err pulses, idx_valid = 0, err_count + 2, locked drops on the second sample. Then 0001, 0010, 0100 → relock.
- **Stall:** in_valid = 0 for 5 cycles mid-stream with garbage on ring_in → outputs and state unchanged. Resume with the next expected value → no error.
- **Saturation and async reset:** force 300 errors → err_count = 255. Assert rst = 0 between clock edges → immediate clear, with no wait for an edge.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-vector phase decoder.
package ring_pkg;

  // Lock-tracking states of the decoder FSM.
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } ring_state_e;

  // Width of the saturating error counter.
  localparam int ERR_W = 8;

  // Widest ring the rotate helper can handle.
  localparam int MAX_W = 32;

  // Rotate the low w bits of v left by one position (MSB wraps to bit 0).
  // Bits at and above position w are returned as zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                            input int unsigned w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] vm;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    vm   = v & mask;
    return ((vm << 1) | (vm >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot qualifier and binary index encoder for a ring vector.
module ring_onehot_decode #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             is_onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  always_comb begin
    is_onehot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);
  end

  // Position of the set bit; only meaningful when the vector is one-hot.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter phase decoder and health monitor.
// Decodes each qualified one-hot sample to an index, acquires lock on a
// correctly rotating sequence, and flags malformed samples and slips while
// locked. While locked the reference keeps rotating on bad samples so a
// single glitch does not desynchronise the tracker.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 3,
  parameter int MISS_LIMIT = 2,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             cycle_done,
  output logic [ERR_W-1:0] err_count,
  output ring_state_e      state_dbg
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  ring_state_e      state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idxv_q, idxv_d;
  logic             locked_q, locked_d;
  logic             oh_err_q, oh_err_d;
  logic             seq_err_q, seq_err_d;
  logic             cdone_q, cdone_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             dec_onehot;
  logic [IDX_W-1:0] dec_idx;
  logic [WIDTH-1:0] exp_vec;
  logic             match;
  logic [GOOD_W-1:0] good_inc;
  logic [MISS_W-1:0] miss_inc;

  ring_onehot_decode #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_dec (
    .vec_i       (ring_in),
    .is_onehot_o (dec_onehot),
    .idx_o       (dec_idx)
  );

  // Expected next sample and the match/increment terms used by the FSM.
  always_comb begin
    exp_vec  = WIDTH'(rotl(MAX_W'(prev_q), WIDTH));
    match    = (ring_in == exp_vec) && dec_onehot;
    good_inc = good_q + GOOD_W'(1);
    miss_inc = miss_q + MISS_W'(1);
  end

  // Next-state logic: FSM transitions, counters, reference and outputs.
  // Nothing changes on cycles without in_valid; pulses default low.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    good_d    = good_q;
    miss_d    = miss_q;
    idx_d     = idx_q;
    idxv_d    = idxv_q;
    err_d     = err_q;
    oh_err_d  = 1'b0;
    seq_err_d = 1'b0;
    cdone_d   = 1'b0;
    if (in_valid) begin
      if (dec_onehot) begin
        idx_d  = dec_idx;
        idxv_d = 1'b1;
      end else begin
        idxv_d = 1'b0;
      end
      case (state_q)
        ST_SEARCH: begin
          if (dec_onehot) begin
            state_d = ST_ACQUIRE;
            good_d  = GOOD_W'(1);
            prev_d  = ring_in;
          end
        end
        ST_ACQUIRE: begin
          if (match) begin
            good_d = good_inc;
            prev_d = ring_in;
            if (good_inc == GOOD_W'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (dec_onehot) begin
            good_d = GOOD_W'(1);
            prev_d = ring_in;
          end else begin
            state_d = ST_SEARCH;
            good_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            prev_d  = ring_in;
            miss_d  = '0;
            cdone_d = (dec_idx == '0);
          end else begin
            oh_err_d  = ~dec_onehot;
            seq_err_d = dec_onehot;
            err_d     = (err_q == '1) ? err_q : err_q + ERR_W'(1);
            prev_d    = exp_vec;
            if (miss_inc == MISS_W'(MISS_LIMIT)) begin
              state_d = ST_SEARCH;
              good_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and registered outputs; asynchronous active-low reset.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SEARCH;
      prev_q    <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      idx_q     <= '0;
      idxv_q    <= 1'b0;
      locked_q  <= 1'b0;
      oh_err_q  <= 1'b0;
      seq_err_q <= 1'b0;
      cdone_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      idx_q     <= idx_d;
      idxv_q    <= idxv_d;
      locked_q  <= locked_d;
      oh_err_q  <= oh_err_d;
      seq_err_q <= seq_err_d;
      cdone_q   <= cdone_d;
      err_q     <= err_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idxv_q;
  assign locked     = locked_q;
  assign onehot_err = oh_err_q;
  assign seq_err    = seq_err_q;
  assign cycle_done = cdone_q;
  assign err_count  = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: randomized and directed ring streams scored
// against a behavioural model that reasons in ring positions.
module tb_ring_decoder;
  import ring_pkg::*;

  localparam int WID  = 4;
  localparam int LOCK = 3;
  localparam int MISS = 2;
  localparam int IW   = $clog2(WID);
  localparam int OW   = IW + 13;

  localparam int M_SEARCH  = 0;
  localparam int M_ACQUIRE = 1;
  localparam int M_LOCKED  = 2;

  // ---------------- clock / reset ----------------
  logic           Clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [WID-1:0] ring_in;
  logic [IW-1:0]  idx;
  logic           idx_valid, locked, onehot_err, seq_err, cycle_done;
  logic [7:0]     err_count;
  ring_state_e    state_dbg;

  always #5 Clk = ~Clk;

  ring_decoder #(.WIDTH(WID), .LOCK_CNT(LOCK), .MISS_LIMIT(MISS)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .ring_in    (ring_in),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .locked     (locked),
    .onehot_err (onehot_err),
    .seq_err    (seq_err),
    .cycle_done (cycle_done),
    .err_count  (err_count),
    .state_dbg  (state_dbg)
  );

  logic [OW-1:0] dut_o;
  assign dut_o = {idx, idx_valid, locked, onehot_err, seq_err, cycle_done, err_count};

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the ring as positions: prev position (-1 = none), counts, outputs.
  int m_mode, m_prev, m_good, m_miss, m_err, m_idx;
  bit m_idxv, m_oe, m_se, m_cd;

  function automatic void model_reset();
    m_mode = M_SEARCH; m_prev = -1; m_good = 0; m_miss = 0; m_err = 0;
    m_idx = 0; m_idxv = 0; m_oe = 0; m_se = 0; m_cd = 0;
  endfunction

  function automatic int next_pos();
    return (m_prev < 0) ? 0 : (m_prev + 1) % WID;
  endfunction

  function automatic logic [WID-1:0] oh(input int i);
    logic [WID-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic void model_step(input bit v, input logic [WID-1:0] r);
    bit is_oh, hit;
    int pos, e;
    m_oe = 0; m_se = 0; m_cd = 0;
    if (!v) return;
    is_oh = ($countones(r) == 1);
    pos = 0;
    for (int i = 0; i < WID; i++) if (r[i]) pos = i;
    if (is_oh) begin m_idx = pos; m_idxv = 1; end else m_idxv = 0;
    e   = (m_prev + 1) % WID;
    hit = is_oh && (m_prev >= 0) && (pos == e);
    if (m_mode == M_SEARCH) begin
      if (is_oh) begin m_mode = M_ACQUIRE; m_good = 1; m_prev = pos; end
    end else if (m_mode == M_ACQUIRE) begin
      if (hit) begin
        m_good++; m_prev = pos;
        if (m_good == LOCK) begin m_mode = M_LOCKED; m_miss = 0; end
      end else if (is_oh) begin
        m_good = 1; m_prev = pos;
      end else begin
        m_mode = M_SEARCH; m_good = 0;
      end
    end else begin
      if (hit) begin
        m_prev = pos; m_miss = 0; m_cd = (pos == 0);
      end else begin
        if (is_oh) m_se = 1; else m_oe = 1;
        if (m_err < 255) m_err++;
        m_miss++;
        m_prev = e;
        if (m_miss == MISS) begin m_mode = M_SEARCH; m_good = 0; m_miss = 0; end
      end
    end
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [IW-1:0] ix;
    ix = IW'(m_idx);
    return {ix, m_idxv, (m_mode == M_LOCKED), m_oe, m_se, m_cd, 8'(m_err)};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [WID-1:0] r);
    @(negedge Clk);
    in_valid = v;
    ring_in  = r;
    model_step(v, r);
    exp_q.push_back(model_out());
  endtask

  task automatic settle();
    @(posedge Clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) check("outputs", 32'(dut_o), 32'(exp_q.pop_front()));
  end

  // ---------------- stimulus ----------------
  initial begin
    int roll, guard;
    model_reset();
    rst = 1'b0; in_valid = 1'b1; ring_in = '0;
    #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      ring_in = WID'($urandom);
      #1;
      check("reset_hold", 32'(dut_o), 32'd0);
    end
    @(negedge Clk);
    rst = 1'b1; in_valid = 1'b0;

    // acquire and lock, wrap
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100);
    step(1, 4'b1000); step(1, 4'b0001); step(1, 4'b0010);
    // slip then flywheel match
    step(1, oh((next_pos() + 2) % WID));
    step(1, oh(next_pos()));
    // loss of lock then relock
    step(1, 4'b0000); step(1, 4'b0000);
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100);
    // stall with garbage, then resume
    for (int i = 0; i < 5; i++) step(0, WID'($urandom));
    step(1, oh(next_pos()));

    // randomized stream
    for (int i = 0; i < 800; i++) begin
      roll = $urandom_range(0, 99);
      if ($urandom_range(0, 99) < 15) step(0, WID'($urandom));
      else if (roll < 75) step(1, oh(next_pos()));
      else if (roll < 88) step(1, WID'($urandom));
      else step(1, oh($urandom_range(0, WID - 1)));
    end

    // saturation: lock, then alternate one bad sample with a flywheel match
    guard = 0;
    while (m_mode != M_LOCKED && guard < 20) begin
      step(1, oh(next_pos()));
      guard++;
    end
    check("sat_lock_reached", 32'(m_mode == M_LOCKED), 32'd1);
    for (int i = 0; i < 300; i++) begin
      step(1, 4'b0000);
      step(1, oh(next_pos()));
    end
    settle();
    check("err_saturated", 32'(err_count), 32'd255);
    check("locked_after_sat", 32'(locked), 32'd1);

    // asynchronous reset between edges
    #1;
    rst = 1'b0;
    #1;
    check("async_reset", 32'(dut_o), 32'd0);
    check("async_reset_state", 32'(state_dbg), 32'(ST_SEARCH));
    model_reset();
    @(negedge Clk);
    rst = 1'b1; in_valid = 1'b0;
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100); step(1, 4'b1000);
    settle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
